// File: rtl/axi_cache_pkg.sv
// Shared encodings, fill-state enum and sizing helpers for the
// cache line-fill path.
package axi_cache_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT
  } fill_state_t;

  function automatic int beats_per_line(
    input int line_bits,
    input int data_width
  );
    return (1 << line_bits) / (data_width / 8);
  endfunction

  function automatic int size_log2(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_fill_master.sv
// Line-fill engine: one AXI4 INCR read burst per cache miss,
// streamed beat by beat into the cache fill port.
module axi_fill_master
  import axi_cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_SIZE_BITS = 7
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    miss,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic [DATA_WIDTH/8-1:0] mem_wstb,
  output logic                    mem_data_valid,
  output logic                    mem_last,
  output logic                    fill_err,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int BEATS = beats_per_line(LINE_SIZE_BITS, DATA_WIDTH);
  localparam int CW    = $clog2(BEATS) + 1;
  localparam int SIZE  = size_log2(DATA_WIDTH);
  localparam int SW    = DATA_WIDTH / 8;

  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << LINE_SIZE_BITS) - ADDR_WIDTH'(1));

  fill_state_t state, state_n;

  logic [ADDR_WIDTH-1:0] base, base_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  err, err_n;

  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic [DATA_WIDTH-1:0] mem_data_n;
  logic [SW-1:0]         mem_wstb_n;
  logic                  mem_valid_n;
  logic                  mem_last_n;
  logic                  fill_err_n;
  logic [ADDR_WIDTH-1:0] araddr_n;
  logic [7:0]            arlen_n;
  logic [2:0]            arsize_n;
  logic [1:0]            arburst_n;
  logic                  arvalid_n;
  logic                  rready_n;

  logic beat;
  logic at_end;
  logic fin;
  logic bad;

  // rready is only ever high in DATA, so a handshake implies DATA
  assign beat   = m_axi_rvalid & m_axi_rready;
  assign at_end = (cnt == LAST_CNT);
  assign fin    = beat & (at_end | m_axi_rlast);
  assign bad    = (m_axi_rresp != RESP_OKAY) | (m_axi_rlast ^ at_end);

  always_comb begin
    state_n     = state;
    base_n      = base;
    cnt_n       = cnt;
    err_n       = err;
    mem_addr_n  = mem_addr;
    mem_data_n  = mem_data_in;
    mem_wstb_n  = '0;
    mem_valid_n = 1'b0;
    mem_last_n  = 1'b0;
    fill_err_n  = 1'b0;
    araddr_n    = m_axi_araddr;
    arlen_n     = m_axi_arlen;
    arsize_n    = m_axi_arsize;
    arburst_n   = m_axi_arburst;
    arvalid_n   = m_axi_arvalid;
    rready_n    = m_axi_rready;

    unique case (state)
      IDLE: begin
        if (miss) begin
          base_n    = cpu_addr & LINE_MASK;
          cnt_n     = '0;
          err_n     = 1'b0;
          araddr_n  = cpu_addr & LINE_MASK;
          arlen_n   = 8'(BEATS - 1);
          arsize_n  = 3'(SIZE);
          arburst_n = BURST_INCR;
          arvalid_n = 1'b1;
          state_n   = ADDR;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          mem_addr_n  = base + (ADDR_WIDTH'(cnt) << SIZE);
          mem_data_n  = m_axi_rdata;
          mem_wstb_n  = '1;
          mem_valid_n = 1'b1;
          cnt_n       = cnt + 1'b1;
          err_n       = err | bad;
          if (fin) begin
            mem_last_n = 1'b1;
            fill_err_n = err | bad;
            rready_n   = 1'b0;
            state_n    = WAIT;
          end
        end
      end
      WAIT: begin
        if (!miss) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      base           <= '0;
      cnt            <= '0;
      err            <= 1'b0;
      mem_addr       <= '0;
      mem_data_in    <= '0;
      mem_wstb       <= '0;
      mem_data_valid <= 1'b0;
      mem_last       <= 1'b0;
      fill_err       <= 1'b0;
      m_axi_araddr   <= '0;
      m_axi_arlen    <= '0;
      m_axi_arsize   <= '0;
      m_axi_arburst  <= '0;
      m_axi_arvalid  <= 1'b0;
      m_axi_rready   <= 1'b0;
    end else begin
      state          <= state_n;
      base           <= base_n;
      cnt            <= cnt_n;
      err            <= err_n;
      mem_addr       <= mem_addr_n;
      mem_data_in    <= mem_data_n;
      mem_wstb       <= mem_wstb_n;
      mem_data_valid <= mem_valid_n;
      mem_last       <= mem_last_n;
      fill_err       <= fill_err_n;
      m_axi_araddr   <= araddr_n;
      m_axi_arlen    <= arlen_n;
      m_axi_arsize   <= arsize_n;
      m_axi_arburst  <= arburst_n;
      m_axi_arvalid  <= arvalid_n;
      m_axi_rready   <= rready_n;
    end
  end

endmodule

// File: tb/tb_axi_fill_master.sv
// Directed bench for axi_fill_master: table of fill scenarios
// driven through one AXI responder task and checked beat by beat.
`timescale 1ns/1ps
module tb_axi_fill_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        miss = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_wstb;
  logic        mem_data_valid;
  logic        mem_last;
  logic        fill_err;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;

  always #5 clk = ~clk;

  axi_fill_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .miss           (miss),
    .cpu_addr       (cpu_addr),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_wstb       (mem_wstb),
    .mem_data_valid (mem_data_valid),
    .mem_last       (mem_last),
    .fill_err       (fill_err),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_arsize   (m_axi_arsize),
    .m_axi_arburst  (m_axi_arburst),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rlast    (m_axi_rlast),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready)
  );

  logic any_out;
  assign any_out = |{mem_addr, mem_data_in, mem_wstb,
                     mem_data_valid, mem_last, fill_err,
                     m_axi_araddr, m_axi_arlen, m_axi_arsize,
                     m_axi_arburst, m_axi_arvalid, m_axi_rready};

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstb;
    logic        last;
    int          c;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    int          stall;
    bit          gaps;
    int          bad;
    int          rl;
    int          abort;
    int          hold;
    logic [31:0] base;
    int          nb;
    bit          err;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  beat_t got_q[$];
  int lasts = 0;
  int errs = 0;
  int errs_at_last = 0;
  int arv_rises = 0;
  int arv_rise_cyc = 0;
  int last_cyc = 0;
  logic arv_d = 1'b0;

  bit have_prev = 1'b0;
  vec_t vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  // passive fill-port / AR observer
  always @(negedge clk) begin
    if (mem_data_valid)
      got_q.push_back('{mem_addr, mem_data_in, mem_wstb, mem_last, cyc});
    if (mem_last) begin
      lasts++;
      last_cyc = cyc;
    end
    if (fill_err) begin
      errs++;
      if (mem_last) errs_at_last++;
    end
    if (m_axi_arvalid && !arv_d) begin
      arv_rises++;
      arv_rise_cyc = cyc;
    end
    arv_d = m_axi_arvalid;
  end

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_fill(input int id, input vec_t v);
    int    g0 = got_q.size();
    int    l0 = lasts;
    int    e0 = errs;
    int    ea0 = errs_at_last;
    int    a0 = arv_rises;
    int    nsend;
    int    k;
    int    n;
    bit    ok;
    bit    rr_ok;
    beat_t exq[$];
    beat_t g;

    cpu_addr = v.addr;
    miss = 1'b1;
    k = 0;
    while (!m_axi_arvalid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check($sformatf("v%0d_ar_latency", id), k, 1);
    if (!m_axi_arvalid) return;

    check($sformatf("v%0d_araddr", id), m_axi_araddr, v.base);
    check($sformatf("v%0d_arlen", id), m_axi_arlen, 31);
    check($sformatf("v%0d_arsize", id), m_axi_arsize, 2);
    check($sformatf("v%0d_arburst", id), m_axi_arburst, 1);

    ok = 1'b1;
    repeat (v.stall) begin
      @(posedge clk); #1;
      if (m_axi_araddr !== v.base || m_axi_arlen !== 8'd31 ||
          m_axi_arvalid !== 1'b1 || m_axi_rready !== 1'b0)
        ok = 1'b0;
    end
    if (v.stall > 0) check($sformatf("v%0d_ar_stable", id), ok, 1);

    m_axi_arready = 1'b1;
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
    check($sformatf("v%0d_ar_done", id),
          {m_axi_arvalid, m_axi_rready}, 2'b01);
    if (have_prev)
      check($sformatf("v%0d_ar_gap", id),
            (arv_rise_cyc - last_cyc) >= 2, 1);

    nsend = (v.rl >= 0) ? v.rl + 1 : 32;
    rr_ok = 1'b1;
    for (int i = 0; i < nsend; i++) begin
      if (v.gaps) begin
        k = $urandom_range(0, 2);
        repeat (k) begin
          @(posedge clk); #1;
        end
      end
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 32'(i);
      m_axi_rresp  = (i == v.bad) ? 2'b10 : 2'b00;
      m_axi_rlast  = (i == v.rl);
      if (i == v.abort) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        check($sformatf("v%0d_reset_outputs", id), any_out, 0);
        reset_n = 1'b1;
        miss = 1'b0;
        break;
      end
      if (m_axi_rready !== 1'b1) rr_ok = 1'b0;
      @(posedge clk); #1;
      exq.push_back('{v.base + 32'(4 * i), 32'(i), 4'hF,
                      (v.abort < 0) && (i == v.nb - 1), cyc});
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
    end
    check($sformatf("v%0d_rready_during", id), rr_ok, 1);
    check($sformatf("v%0d_rready_off", id), m_axi_rready, 0);

    if (v.abort < 0) begin
      repeat (v.hold) begin
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      miss = 1'b0;
    end
    @(posedge clk); #1;

    n = got_q.size() - g0;
    check($sformatf("v%0d_beat_count", id), n, v.nb);
    for (int i = 0; i < n && i < exq.size(); i++) begin
      g = got_q[g0 + i];
      check($sformatf("v%0d_b%0d_addr", id, i), g.addr, exq[i].addr);
      check($sformatf("v%0d_b%0d_data", id, i), g.data, exq[i].data);
      check($sformatf("v%0d_b%0d_wstb_last", id, i),
            {g.wstb, g.last}, {exq[i].wstb, exq[i].last});
      check($sformatf("v%0d_b%0d_cycle", id, i), g.c, exq[i].c);
    end
    check($sformatf("v%0d_last_count", id), lasts - l0,
          (v.abort < 0) ? 1 : 0);
    check($sformatf("v%0d_fill_err_count", id), errs - e0, v.err);
    check($sformatf("v%0d_fill_err_with_last", id),
          errs_at_last - ea0, v.err);
    check($sformatf("v%0d_ar_count", id), arv_rises - a0, 1);
    have_prev = (v.abort < 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //        addr          stl gap bad rl  abrt hold base          nb  err
    vecs[0] = '{32'h0000_12F4, 0, 1'b0, -1, 31, -1, 0, 32'h0000_1280, 32, 1'b0};
    vecs[1] = '{32'h0000_4005, 5, 1'b1, -1, 31, -1, 3, 32'h0000_4000, 32, 1'b0};
    vecs[2] = '{32'hABCD_EF7F, 1, 1'b0,  7, 31, -1, 0, 32'hABCD_EF00, 32, 1'b1};
    vecs[3] = '{32'h0000_0100, 0, 1'b0, -1, 15, -1, 0, 32'h0000_0100, 16, 1'b1};
    vecs[4] = '{32'h0000_02FF, 0, 1'b1, -1, -1, -1, 0, 32'h0000_0280, 32, 1'b1};
    vecs[5] = '{32'hFFFF_FFC4, 0, 1'b0, -1, 31, -1, 0, 32'hFFFF_FF80, 32, 1'b0};
    vecs[6] = '{32'h0000_3050, 0, 1'b0, -1, 31, 10, 0, 32'h0000_3000, 10, 1'b0};
    vecs[7] = '{32'h0000_12F4, 0, 1'b0, -1, 31, -1, 0, 32'h0000_1280, 32, 1'b0};

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", any_out, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_miss", m_axi_arvalid, 0);

    for (int v = 0; v < 8; v++) run_fill(v, vecs[v]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_fill_master.md
# axi_fill_master

Line-fill engine between the cache and an AXI4 read port. While the cache holds `miss` high, the block issues one AXI4 INCR read burst for the line containing `cpu_addr`. It streams the returned beats into the cache's fill interface (`mem_addr`, `mem_data_in`, `mem_wstb`, `mem_data_valid`, `mem_last`) and then waits for the cache to release `miss` before it accepts the next request.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width; must match the cache.
- DATA_WIDTH, 32, AXI and fill data width; must be a power of two, at least 8.
- LINE_SIZE_BITS, 7, log2 of line bytes; must match the cache. BEATS = 2^LINE_SIZE_BITS / (DATA_WIDTH/8), range 1..256.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset: synchronous, active-low.
- miss  in  1  cache miss; fill request while high.
- cpu_addr  in  ADDR_WIDTH  missing address; sampled in IDLE.
- mem_addr  out  ADDR_WIDTH  byte address of the current fill beat.
- mem_data_in  out  DATA_WIDTH  fill data (named for the cache port it drives).
- mem_wstb  out  DATA_WIDTH/8  byte strobes; all ones when valid.
- mem_data_valid  out  1  fill beat valid.
- mem_last  out  1  final beat of the line.
- fill_err  out  1  one-cycle pulse per fill with a response or length error.
- m_axi_araddr  out  ADDR_WIDTH; m_axi_arlen  out  8; m_axi_arsize  out  3; m_axi_arburst  out  2; m_axi_arvalid  out  1; m_axi_arready  in  1.
- m_axi_rdata  in  DATA_WIDTH; m_axi_rresp  in  2; m_axi_rlast  in  1; m_axi_rvalid  in  1; m_axi_rready  out  1.

## Operation
- States: IDLE, ADDR, DATA, WAIT.
- **IDLE**
  - On `miss`=1: latch `base` = `cpu_addr` with the low LINE_SIZE_BITS bits cleared.
  - Clear the beat counter and the error flag; go to ADDR.
- **ADDR**
  - Drive `arvalid`=1, `araddr`=`base`, `arlen`=BEATS-1, `arsize`=log2(DATA_WIDTH/8), `arburst`=2'b01 (INCR).
  - Hold all AR fields stable until `arvalid` and `arready` are both high, then go to DATA.
- **DATA**
  - `rready`=1 on every cycle; there is no backpressure from the cache.
  - For each beat with `rvalid`&`rready`, register the beat to the fill port:
    - `mem_data_in` = `rdata`; `mem_wstb` = all ones; `mem_data_valid` = 1.
    - `mem_addr` = `base` + cnt*(DATA_WIDTH/8), computed modulo 2^ADDR_WIDTH; cnt is a log2(BEATS)+1-bit counter.
  - The final beat is the first of: cnt == BEATS-1, or `rlast`=1.
    - On the final beat, set `mem_last`=1 and go to WAIT.
- **Errors**
  - Any beat with `rresp` != 2'b00 sets the error flag; the beat is still delivered.
  - `rlast` without cnt == BEATS-1 sets the error flag. The fill ends on that beat, so the rest of the line holds stale data.
  - cnt == BEATS-1 without `rlast` sets the error flag. Further R beats are not accepted; the interconnect must not over-deliver.
  - `fill_err` pulses in the cycle the final beat is presented, if the flag is set.
- **WAIT**
  - Stay until `miss`=0, then go to IDLE. This stops the same miss from starting a second fill.
- **Reset**
  - Outputs reset to 0: all `mem_*`, `fill_err`, `arvalid`, `rready`, `araddr`, `arlen`, `arsize`, `arburst`.
  - State resets to IDLE.
  - Reset mid-burst abandons the transaction. The cache and the interconnect must be reset together.

## Timing
- `miss` high at edge N puts `arvalid` high in cycle N+1.
- AR handshake at edge A puts `rready` high from cycle A+1.
- Fill latency is one cycle: an R beat accepted at edge B is presented on the `mem_*` outputs during cycle B+1.
- `mem_data_valid` is high for exactly one cycle per beat. Back-to-back `rvalid` gives back-to-back fill beats.
- The cache drops `miss` in the cycle after `mem_last`. WAIT therefore lasts at least 1 cycle, so the next fill's `arvalid` comes no earlier than 2 cycles after `mem_last`.
- `miss` must not drop during ADDR or DATA. If it does, it is ignored and the fill completes.

## Structure
- Shared package `axi_cache_pkg` holds:
  - AXI encodings: BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - The fill-state enum.
  - Helper functions: beats_per_line(), log2 for arsize.
- Single flat module with no sub-module. The counter, address generation and FSM are small enough to keep together.

## Test plan
- **Basic fill:** `miss`=1 at `cpu_addr`=0x0000_12F4 → `araddr`=0x0000_1280, `arlen`=31, `arsize`=2, `arburst`=1. Send 32 back-to-back beats with data=i → the cache sees `mem_addr` 0x1280..0x12FC, data 0..31, `mem_last` on beat 31, and line-read back-to-back data 0..31.
- **Stalls:** `arready` low for 5 cycles → AR fields stay stable. Random `rvalid` gaps → beats still delivered in order, one cycle after each is accepted, and `mem_last` appears only once.
- **Bad response:** `rresp`=2'b10 on beat 7 → all 32 beats delivered, `fill_err` pulses exactly once, with `mem_last`.
- **Early rlast:** `rlast` on beat 15 → `mem_last` on beat 15, `fill_err`=1, then WAIT. Missing `rlast` on beat 31 → `mem_last` on beat 31, `fill_err`=1.
- **Miss handshake:** `miss` held high 3 cycles after `mem_last` → no second AR. Two misses back-to-back to different lines → two bursts, second `arvalid` at least 2 cycles after the first fill's `mem_last`.
- **Reset mid-burst:** `reset_n`=0 at beat 10 → next cycle all outputs are 0 and the block is in IDLE. A new `miss` after reset gives a clean 32-beat fill.
